buffer_arbiter: RTL and testbench
=================================

Name: buffer_arbiter

Overview:
- Sequences and shares the 64-byte packet data buffer between the AHB-Lite slave and the USB RX/TX packet engines.
- Owns the buffer_reserved select and issues the buffer's one-cycle access strobes.
- Checks capacity against buffer_occupancy before granting any access.
- Sits between the AHB slave, the RX/TX engines and the data buffer; the protocol controller supplies clear.

Parameters:
- DEPTH, 64: buffer capacity in bytes; full when occupancy equals DEPTH.
- MAX_WAIT, 200: AHB wait-cycle limit before ahb_timeout (optional feature only).
- WAIT_W, 8: width of the AHB wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- clear  in  1  from protocol controller: abort, return to IDLE, clear sticky flags.
- ahb_req  in  1  AHB requests one buffer access; held until ahb_grant.
- ahb_write  in  1  1 = store_tx_data, 0 = get_rx_data; valid with ahb_req.
- ahb_size  in  2  access size; bytes = ahb_size+1; valid with ahb_req.
- rx_req  in  1  RX has one byte to store (single-cycle pulse).
- tx_req  in  1  TX wants one byte (single-cycle pulse).
- usb_active  in  1  RX or TX packet in progress; USB side must keep the buffer.
- buffer_occupancy  in  7  current byte count from data buffer.
- buffer_reserved  out  1  1 = AHB owns the buffer, 0 = USB owns it.
- store_tx_data  out  1  AHB write strobe to buffer.
- get_rx_data  out  1  AHB read strobe to buffer.
- data_size  out  2  registered copy of ahb_size, valid with AHB strobes.
- store_rx_packet_data  out  1  RX write strobe to buffer.
- get_tx_packet_data  out  1  TX read strobe to buffer.
- ahb_grant  out  1  one-cycle pulse, coincident with the AHB strobe.
- rx_overflow  out  1  sticky: RX byte dropped because buffer full.
- tx_underrun  out  1  sticky: TX byte requested from empty buffer.
- ahb_timeout  out  1  sticky: AHB starved for MAX_WAIT cycles.

Behaviour:
- All outputs are registered. Reset values: buffer_reserved=0, data_size=0, every other output 0. State = IDLE.
- States: IDLE, USB, AHB, SWITCH.
- IDLE transitions:
  - usb_active=1, or rx_req/tx_req present -> USB (USB has priority).
  - Otherwise ahb_req -> AHB.
  - Each transition sets buffer_reserved to the new owner's value on the same edge.
- USB state, rx_req:
  - If occupancy < DEPTH, store_rx_packet_data pulses the next cycle.
  - Otherwise the byte is dropped and rx_overflow sets.
- USB state, tx_req:
  - If occupancy > 0, get_tx_packet_data pulses the next cycle.
  - Otherwise tx_underrun sets.
- USB state, simultaneous rx_req and tx_req: RX is served first; TX is held one cycle, then served.
- USB -> SWITCH when usb_active=0, no USB request is pending, and ahb_req=1. USB -> IDLE when usb_active=0 and no request of any kind is present.
- AHB state, capacity check at grant time:
  - Write is legal when occupancy + bytes <= DEPTH.
  - Read is legal when occupancy >= bytes.
- AHB state, legal access:
  - The strobe, data_size and ahb_grant pulse together one cycle after the request is sampled.
  - The arbiter then inserts one idle cycle so occupancy settles; at most one AHB strobe every 2 cycles.
- AHB state, illegal access: no strobe and no grant; the request stays pending. It is granted once capacity permits, or clear discards it.
- AHB state exits:
  - usb_active=1 or any USB request -> SWITCH. The USB request is not lost: it is held one cycle in a pending register.
  - ahb_req=0 and no USB activity -> IDLE.
- An in-flight AHB strobe cycle always completes before the switch.
- SWITCH: exactly one cycle with no strobes; buffer_reserved flips at its exit. It then enters the pending owner, with USB first if both are pending.
- Occupancy arithmetic uses 7-bit unsigned values; bytes is zero-extended. DEPTH=64 is a legal occupancy value.
- clear: same edge -> IDLE; pending requests and sticky flags cleared; strobes deasserted next cycle. clear has priority over all requests.
- rst asserted mid-access: all strobes drop immediately (asynchronous); nothing is held across reset.

Optional Feature:
- Macro BUFFER_ARB_STARVE_EN.
- Defined:
  - A WAIT_W counter increments each cycle ahb_req=1 without ahb_grant. It clears on grant or clear.
  - At MAX_WAIT, ahb_timeout sets (sticky until clear).
  - On the next usb_active=0 cycle, AHB is given priority over a new USB request.
- Undefined: no counter; ahb_timeout tied 0; USB always has priority.

Test Plan:
- Reset check: rst=1 -> all outputs 0, state IDLE. Release, ahb_req=1, write, size=3, occupancy=0 -> store_tx_data, ahb_grant, data_size=3 one cycle later, buffer_reserved=1.
- AHB capacity: occupancy=62, write size=3 -> no strobe, request held. Occupancy driven to 60 -> grant next cycle. Read size=1 with occupancy=1 -> stalled.
- USB boundaries: usb_active=1, rx_req at occupancy=64 -> no store_rx_packet_data, rx_overflow=1. tx_req at occupancy=0 -> tx_underrun=1. clear -> both 0.
- Ownership switch: AHB reading, usb_active rises -> current strobe completes, one SWITCH cycle with no strobes, buffer_reserved=0, then the pending rx_req is stored.
- Simultaneous events: rx_req and tx_req in the same cycle -> store_rx_packet_data, then get_tx_packet_data the following cycle. clear with ahb_req pending -> no grant, state IDLE.
- Starvation (BUFFER_ARB_STARVE_EN, MAX_WAIT=10): usb_active held 12 cycles with ahb_req=1 -> ahb_timeout=1 at the 10th wait cycle; AHB granted before a new rx_req once usb_active=0. Without the macro, ahb_timeout stays 0.

Source files
------------

// File: rtl/buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : buffer_arbiter
// Purpose  : Shares the 64-byte packet buffer between the AHB slave and the
//            USB RX/TX engines. Optional AHB starvation guard: BUFFER_ARB_STARVE_EN.
// Revision : 1.0
// ============================================================================
module buffer_arbiter #(
  parameter int DEPTH    = 64,
  parameter int MAX_WAIT = 200,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       ahb_req,
  input  logic       ahb_write,
  input  logic [1:0] ahb_size,
  input  logic       rx_req,
  input  logic       tx_req,
  input  logic       usb_active,
  input  logic [6:0] buffer_occupancy,
  output logic       buffer_reserved,
  output logic       store_tx_data,
  output logic       get_rx_data,
  output logic [1:0] data_size,
  output logic       store_rx_packet_data,
  output logic       get_tx_packet_data,
  output logic       ahb_grant,
  output logic       rx_overflow,
  output logic       tx_underrun,
  output logic       ahb_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_USB    = 2'd1,
    S_AHB    = 2'd2,
    S_SWITCH = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_rx_pend, r_tx_pend, r_gap;
  logic       w_rx_pend_nxt, w_tx_pend_nxt, w_gap_nxt, w_reserved_nxt;
  logic       w_store_tx_nxt, w_get_rx_nxt, w_store_rx_nxt, w_get_tx_nxt;
  logic       w_grant_nxt, w_ovf_nxt, w_und_nxt;
  logic [1:0] w_size_nxt;
  logic [6:0] w_bytes;
  logic [7:0] w_sum;
  logic       w_ahb_ok, w_rx_any, w_tx_any, w_usb_evt, w_ahb_first;

  if ((MAX_WAIT >> WAIT_W) != 0) begin : g_wait_w_check
    $error("buffer_arbiter: MAX_WAIT does not fit in WAIT_W");
  end

  assign w_bytes   = {5'd0, ahb_size} + 7'd1;
  assign w_sum     = {1'b0, buffer_occupancy} + {1'b0, w_bytes};
  assign w_ahb_ok  = ahb_write ? (w_sum <= 8'(DEPTH)) : (buffer_occupancy >= w_bytes);
  assign w_rx_any  = rx_req | r_rx_pend;
  assign w_tx_any  = tx_req | r_tx_pend;
  assign w_usb_evt = usb_active | w_rx_any | w_tx_any;

  always_comb begin
    w_state_nxt    = r_state;
    w_rx_pend_nxt  = w_rx_any;
    w_tx_pend_nxt  = w_tx_any;
    w_gap_nxt      = 1'b0;
    w_reserved_nxt = buffer_reserved;
    w_store_tx_nxt = 1'b0;
    w_get_rx_nxt   = 1'b0;
    w_size_nxt     = data_size;
    w_store_rx_nxt = 1'b0;
    w_get_tx_nxt   = 1'b0;
    w_grant_nxt    = 1'b0;
    w_ovf_nxt      = rx_overflow;
    w_und_nxt      = tx_underrun;
    case (r_state)
      S_IDLE: begin
        if (w_usb_evt && !w_ahb_first) begin
          w_state_nxt    = S_USB;
          w_reserved_nxt = 1'b0;
        end else if (ahb_req) begin
          w_state_nxt    = S_AHB;
          w_reserved_nxt = 1'b1;
        end
      end
      S_USB: begin
        if (w_ahb_first) begin
          w_state_nxt = S_SWITCH;
        end else begin
          // RX wins a tie; the TX request stays in its pending register
          if (w_rx_any) begin
            if (buffer_occupancy < 7'(DEPTH)) w_store_rx_nxt = 1'b1;
            else                              w_ovf_nxt      = 1'b1;
            w_rx_pend_nxt = r_rx_pend & rx_req;
          end else if (w_tx_any) begin
            if (buffer_occupancy != 7'd0) w_get_tx_nxt = 1'b1;
            else                          w_und_nxt    = 1'b1;
            w_tx_pend_nxt = r_tx_pend & tx_req;
          end
          if (!usb_active && !w_rx_any && !w_tx_any)
            w_state_nxt = ahb_req ? S_SWITCH : S_IDLE;
        end
      end
      S_AHB: begin
        if (w_usb_evt && !w_ahb_first) begin
          w_state_nxt = S_SWITCH;
        end else if (ahb_req) begin
          // r_gap forces one idle cycle after each grant so occupancy settles
          if (!r_gap && w_ahb_ok) begin
            w_grant_nxt    = 1'b1;
            w_store_tx_nxt = ahb_write;
            w_get_rx_nxt   = ~ahb_write;
            w_size_nxt     = ahb_size;
            w_gap_nxt      = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SWITCH: begin
        if (w_usb_evt && !w_ahb_first) begin
          w_state_nxt    = S_USB;
          w_reserved_nxt = 1'b0;
        end else if (ahb_req) begin
          w_state_nxt    = S_AHB;
          w_reserved_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear) begin
      w_state_nxt    = S_IDLE;
      w_rx_pend_nxt  = 1'b0;
      w_tx_pend_nxt  = 1'b0;
      w_gap_nxt      = 1'b0;
      w_reserved_nxt = 1'b0;
      w_store_tx_nxt = 1'b0;
      w_get_rx_nxt   = 1'b0;
      w_store_rx_nxt = 1'b0;
      w_get_tx_nxt   = 1'b0;
      w_grant_nxt    = 1'b0;
      w_ovf_nxt      = 1'b0;
      w_und_nxt      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_pend            <= 1'b0;
      r_tx_pend            <= 1'b0;
      r_gap                <= 1'b0;
      buffer_reserved      <= 1'b0;
      store_tx_data        <= 1'b0;
      get_rx_data          <= 1'b0;
      data_size            <= 2'd0;
      store_rx_packet_data <= 1'b0;
      get_tx_packet_data   <= 1'b0;
      ahb_grant            <= 1'b0;
      rx_overflow          <= 1'b0;
      tx_underrun          <= 1'b0;
    end else begin
      r_rx_pend            <= w_rx_pend_nxt;
      r_tx_pend            <= w_tx_pend_nxt;
      r_gap                <= w_gap_nxt;
      buffer_reserved      <= w_reserved_nxt;
      store_tx_data        <= w_store_tx_nxt;
      get_rx_data          <= w_get_rx_nxt;
      data_size            <= w_size_nxt;
      store_rx_packet_data <= w_store_rx_nxt;
      get_tx_packet_data   <= w_get_tx_nxt;
      ahb_grant            <= w_grant_nxt;
      rx_overflow          <= w_ovf_nxt;
      tx_underrun          <= w_und_nxt;
    end
  end

`ifdef BUFFER_ARB_STARVE_EN
  localparam logic [WAIT_W-1:0] c_wait_max  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_starve_prio;

  // Priority lasts until the starved request is finally granted
  assign w_ahb_first = r_starve_prio & ahb_req & ~usb_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_starve_prio <= 1'b0;
      ahb_timeout   <= 1'b0;
    end else if (clear) begin
      r_wait_cnt    <= '0;
      r_starve_prio <= 1'b0;
      ahb_timeout   <= 1'b0;
    end else if (w_grant_nxt) begin
      r_wait_cnt    <= '0;
      r_starve_prio <= 1'b0;
    end else if (ahb_req && !ahb_grant && (r_wait_cnt != c_wait_max)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_wait_cnt == c_wait_last) begin
        ahb_timeout   <= 1'b1;
        r_starve_prio <= 1'b1;
      end
    end
  end
`else
  assign w_ahb_first = 1'b0;
  assign ahb_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_buffer_arbiter.sv
`default_nettype none
// tb_buffer_arbiter: directed vectors with hand-computed expectations for buffer_arbiter.
module tb_buffer_arbiter;

  logic       clk = 1'b0;
  logic       rst, clear, ahb_req, ahb_write, rx_req, tx_req, usb_active;
  logic [1:0] ahb_size;
  logic [6:0] occ;
  logic       buffer_reserved, store_tx_data, get_rx_data, store_rx_packet_data;
  logic       get_tx_packet_data, ahb_grant, rx_overflow, tx_underrun, ahb_timeout;
  logic [1:0] data_size;
  logic [10:0] w_outs;

  int n_chk  = 0;
  int n_pass = 0;
  int g_at, s_at, exp_g, exp_s;
  logic exp_to;

  buffer_arbiter #(.DEPTH(64), .MAX_WAIT(10), .WAIT_W(8)) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .clear                (clear),
    .ahb_req              (ahb_req),
    .ahb_write            (ahb_write),
    .ahb_size             (ahb_size),
    .rx_req               (rx_req),
    .tx_req               (tx_req),
    .usb_active           (usb_active),
    .buffer_occupancy     (occ),
    .buffer_reserved      (buffer_reserved),
    .store_tx_data        (store_tx_data),
    .get_rx_data          (get_rx_data),
    .data_size            (data_size),
    .store_rx_packet_data (store_rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .ahb_grant            (ahb_grant),
    .rx_overflow          (rx_overflow),
    .tx_underrun          (tx_underrun),
    .ahb_timeout          (ahb_timeout)
  );

  always #5 clk = ~clk;

  assign w_outs = {buffer_reserved, store_tx_data, get_rx_data, data_size, store_rx_packet_data,
                   get_tx_packet_data, ahb_grant, rx_overflow, tx_underrun, ahb_timeout};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; ahb_req = 1'b0; ahb_write = 1'b0; ahb_size = 2'd0;
    rx_req = 1'b0; tx_req = 1'b0; usb_active = 1'b0; occ = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 16'(w_outs), 16'd0);
    rst = 1'b0;

    // AHB write from IDLE, then back-to-back request respects the idle gap
    ahb_req = 1'b1; ahb_write = 1'b1; ahb_size = 2'd3; occ = 7'd0;
    tick();
    chk("idle_to_ahb_owner", 16'(buffer_reserved), 16'd1);
    chk("idle_to_ahb_no_grant", 16'(ahb_grant), 16'd0);
    tick();
    chk("wr_grant_strobe_size", 16'({ahb_grant, store_tx_data, get_rx_data, data_size}), 16'b11011);
    ahb_size = 2'd0; occ = 7'd4;
    tick();
    chk("gap_after_grant", 16'({ahb_grant, store_tx_data}), 16'd0);
    tick();
    chk("second_grant_size0", 16'({ahb_grant, store_tx_data, data_size}), 16'b1100);
    ahb_req = 1'b0;
    tick();
    chk("ahb_release", 16'({ahb_grant, store_tx_data}), 16'd0);

    // Capacity: write 4 bytes at 62 stalls, allowed at 60
    ahb_req = 1'b1; ahb_write = 1'b1; ahb_size = 2'd3; occ = 7'd62;
    tick();
    tick();
    chk("wr_full_stall_a", 16'({ahb_grant, store_tx_data}), 16'd0);
    tick();
    chk("wr_full_stall_b", 16'({ahb_grant, store_tx_data}), 16'd0);
    occ = 7'd60;
    tick();
    chk("wr_exact_fit_grant", 16'({ahb_grant, store_tx_data}), 16'b11);
    ahb_req = 1'b0;
    tick();

    // Capacity: read 2 bytes at 1 stalls, allowed at 2
    ahb_req = 1'b1; ahb_write = 1'b0; ahb_size = 2'd1; occ = 7'd1;
    tick();
    tick();
    chk("rd_empty_stall", 16'({ahb_grant, get_rx_data}), 16'd0);
    occ = 7'd2;
    tick();
    chk("rd_grant", 16'({ahb_grant, get_rx_data, store_tx_data, data_size}), 16'b11001);
    ahb_req = 1'b0;
    tick();

    // USB boundaries
    usb_active = 1'b1; rx_req = 1'b1; occ = 7'd64;
    tick();
    rx_req = 1'b0;
    chk("usb_owner", 16'(buffer_reserved), 16'd0);
    tick();
    chk("rx_overflow", 16'({store_rx_packet_data, rx_overflow}), 16'b01);
    tx_req = 1'b1; occ = 7'd0;
    tick();
    tx_req = 1'b0;
    chk("tx_underrun", 16'({get_tx_packet_data, tx_underrun}), 16'b01);
    rx_req = 1'b1; occ = 7'd63;
    tick();
    rx_req = 1'b0;
    chk("rx_store_63", 16'(store_rx_packet_data), 16'd1);
    tx_req = 1'b1; occ = 7'd1;
    tick();
    tx_req = 1'b0;
    chk("tx_get_1", 16'({store_rx_packet_data, get_tx_packet_data}), 16'b01);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_flags", 16'({rx_overflow, tx_underrun}), 16'd0);
    tick();

    // Simultaneous RX and TX: RX first, TX one cycle later
    occ = 7'd10; rx_req = 1'b1; tx_req = 1'b1;
    tick();
    rx_req = 1'b0; tx_req = 1'b0;
    chk("simul_rx_first", 16'({store_rx_packet_data, get_tx_packet_data}), 16'b10);
    tick();
    chk("simul_tx_second", 16'({store_rx_packet_data, get_tx_packet_data}), 16'b01);
    tick();
    chk("simul_done", 16'({store_rx_packet_data, get_tx_packet_data}), 16'b00);

    // Ownership switch AHB -> USB -> AHB
    usb_active = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    ahb_req = 1'b1; ahb_write = 1'b0; ahb_size = 2'd0; occ = 7'd20;
    tick();
    tick();
    chk("sw_inflight_read", 16'({get_rx_data, ahb_grant}), 16'b11);
    usb_active = 1'b1; rx_req = 1'b1;
    tick();
    rx_req = 1'b0;
    chk("sw_cycle_quiet", 16'({buffer_reserved, get_rx_data, ahb_grant, store_rx_packet_data}), 16'b1000);
    tick();
    chk("sw_to_usb", 16'({buffer_reserved, get_rx_data, store_rx_packet_data}), 16'b000);
    tick();
    chk("sw_pending_rx_stored", 16'(store_rx_packet_data), 16'd1);
    usb_active = 1'b0;
    tick();
    tick();
    chk("sw_back_to_ahb", 16'({buffer_reserved, ahb_grant}), 16'b10);
    tick();
    chk("sw_ahb_grant", 16'({ahb_grant, get_rx_data}), 16'b11);
    ahb_req = 1'b0;
    tick();

    // clear discards a stalled AHB request and returns to IDLE
    ahb_req = 1'b1; ahb_write = 1'b1; ahb_size = 2'd3; occ = 7'd62;
    tick();
    tick();
    clear = 1'b1; occ = 7'd0;
    tick();
    clear = 1'b0;
    chk("clear_no_grant", 16'({ahb_grant, store_tx_data}), 16'd0);
    tick();
    chk("clear_went_idle", 16'({buffer_reserved, ahb_grant}), 16'b10);
    tick();
    chk("after_clear_grant", 16'(ahb_grant), 16'd1);
    ahb_req = 1'b0;
    tick();

    // Starvation: AHB waits behind a long USB transfer
`ifdef BUFFER_ARB_STARVE_EN
    exp_to = 1'b1; exp_g = 3; exp_s = 6;
`else
    exp_to = 1'b0; exp_g = 4; exp_s = 1;
`endif
    usb_active = 1'b1; ahb_req = 1'b1; ahb_write = 1'b1; ahb_size = 2'd0; occ = 7'd0;
    repeat (12) tick();
    chk("starve_timeout", 16'(ahb_timeout), 16'(exp_to));
    usb_active = 1'b0; rx_req = 1'b1;
    g_at = 0; s_at = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      rx_req = 1'b0;
      if (ahb_grant) begin
        g_at = t;
        ahb_req = 1'b0;
      end
      if (store_rx_packet_data) s_at = t;
    end
    chk("starve_grant_cycle", 16'(g_at), 16'(exp_g));
    chk("starve_store_cycle", 16'(s_at), 16'(exp_s));

    // Asynchronous reset drops an in-flight strobe immediately
    ahb_req = 1'b1; ahb_write = 1'b1; ahb_size = 2'd0; occ = 7'd0;
    tick();
    tick();
    chk("pre_reset_grant", 16'({ahb_grant, store_tx_data}), 16'b11);
    rst = 1'b1;
    #1;
    chk("async_reset_drop", 16'(w_outs), 16'd0);
    ahb_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
